// File: rtl/sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// sr_latch_ctrl
//
// Initiator-side controller for an external (possibly asynchronous) SR latch.
// A command is accepted over a valid/ready handshake. The controller then
// drives a fixed-width S or R pulse, waits for the latch outputs to confirm the
// new state through a 2-flop synchronizer, and reports completion with a
// one-cycle done pulse. The err output is raised with done when the latch does
// not confirm within TIMEOUT cycles.
//
// Parameters:
//   PULSE_W  - cycles S or R is held high per command (>= 1)
//   TIMEOUT  - max cycles spent waiting for q/qbar confirmation (>= 1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command request
//   cmd_op     in   1 = set (drive S), 0 = reset (drive R); sampled on accept
//   cmd_ready  out  high only in IDLE
//   S, R       out  registered latch drives, mutually exclusive
//   q, qbar    in   latch outputs (asynchronous domain)
//   done       out  one-cycle completion pulse
//   err        out  one-cycle failure flag, coincident with done
//   state_q    out  last successfully confirmed latch state
//   busy       out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module sr_latch_ctrl #(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_op,
    output logic cmd_ready,
    output logic S,
    output logic R,
    input  logic q,
    input  logic qbar,
    output logic done,
    output logic err,
    output logic state_q,
    output logic busy
);

    localparam int MAX_CNT = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           fsm_q;
    logic [CNT_W-1:0] cnt_q;        // pulse or wait counter, cleared on every state entry
    logic             op_q;         // command latched on accept
    logic             s_q;
    logic             r_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             latch_state_q;
    logic             busy_q;

    // Two-stage synchronizers for the asynchronous latch feedback.
    logic [1:0] q_sync_q;
    logic [1:0] qbar_sync_q;
    logic       q_s;
    logic       qbar_s;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sync_q    <= 2'b00;
            qbar_sync_q <= 2'b00;
        end else begin
            q_sync_q    <= {q_sync_q[0], q};
            qbar_sync_q <= {qbar_sync_q[0], qbar};
        end
    end

    assign q_s    = q_sync_q[1];
    assign qbar_s = qbar_sync_q[1];

    // q_s == qbar_s (illegal or settling) never matches, so it simply counts
    // as not yet confirmed.
    logic confirmed;
    assign confirmed = (q_s == op_q) && (qbar_s == ~op_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q         <= IDLE;
            cnt_q         <= '0;
            op_q          <= 1'b0;
            s_q           <= 1'b0;
            r_q           <= 1'b0;
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            latch_state_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // done/err are single-cycle pulses; they only rise on WAIT exit.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (fsm_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op;
                        s_q     <= cmd_op;
                        r_q     <= ~cmd_op;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        fsm_q   <= PULSE;
                    end
                end

                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        s_q   <= 1'b0;
                        r_q   <= 1'b0;
                        cnt_q <= '0;
                        fsm_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                WAIT: begin
                    // Success is tested first so it wins over a coincident timeout.
                    if (confirmed) begin
                        done_q        <= 1'b1;
                        latch_state_q <= op_q;
                        cnt_q         <= '0;
                        fsm_q         <= DONE;
                    end else if (cnt_q == WAIT_LAST) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        cnt_q  <= '0;
                        fsm_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    fsm_q   <= IDLE;
                end

                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign S         = s_q;
    assign R         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_q   = latch_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_ctrl
//
// Bench for sr_latch_ctrl. A behavioural SR latch drives q/qbar: in normal
// mode it follows S/R one clock later; in forced modes q/qbar are pinned to
// chosen values (stuck or illegal feedback). For each command the expected
// completion cycle is derived from the controller's timing rules: the
// command's pulse length, 2 synchronizer stages, and the timeout.
// -----------------------------------------------------------------------------
module tb_sr_latch_ctrl;

    localparam int W  = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_op = 1'b0;
    logic cmd_ready, S, R, q, qbar, done, err, state_q, busy;

    int chk_cnt  = 0;
    int fail_cnt = 0;
    bit exp_state = 1'b0;

    sr_latch_ctrl #(.PULSE_W(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .S         (S),
        .R         (R),
        .q         (q),
        .qbar      (qbar),
        .done      (done),
        .err       (err),
        .state_q   (state_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- latch model ----------------
    typedef enum logic [1:0] {M_NORMAL, M_FORCED} mode_e;
    mode_e mode = M_NORMAL;
    logic  force_q  = 1'b0;
    logic  force_qb = 1'b1;
    logic  lat_q    = 1'b0;
    logic  lat_qb   = 1'b1;

    always @(posedge clk) begin
        if (mode != M_NORMAL) begin
            lat_q  <= force_q;
            lat_qb <= force_qb;
        end else if (S) begin
            lat_q  <= 1'b1;
            lat_qb <= 1'b0;
        end else if (R) begin
            lat_q  <= 1'b0;
            lat_qb <= 1'b1;
        end
    end

    assign q    = (mode == M_NORMAL) ? lat_q  : force_q;
    assign qbar = (mode == M_NORMAL) ? lat_qb : force_qb;

    // ---------------- helpers ----------------
    task automatic idle(input int cycles);
        cmd_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic set_mode(input mode_e m, input logic fq, input logic fqb);
        @(negedge clk);
        force_q  = fq;
        force_qb = fqb;
        mode     = m;
        idle(3);
    endtask

    // Issues one command from a negedge where cmd_ready is known high and
    // checks every cycle until one cycle after completion. With hold set,
    // cmd_valid stays high and cmd_op toggles every cycle.
    task automatic run_cmd(input bit op, input bit hold, input string tag, output bit next_op);
        int d;
        bit exp_err;
        bit e_s, e_r, e_done, e_err, e_busy, e_ready;
        if ((q == op) && (qbar == !op)) begin
            d = W + 1;                         // already confirmed: first WAIT cycle
            exp_err = 1'b0;
        end else if (mode == M_NORMAL) begin
            d = (W + 1 > 4) ? W + 1 : 4;       // latch moves 1 cycle after S/R, then 2 sync stages
            exp_err = 1'b0;
        end else begin
            d = W + TO;                        // never confirms: full timeout
            exp_err = 1'b1;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge clk);
        for (int n = 0; n <= d + 1; n++) begin
            @(negedge clk);
            e_s     = op && (n < W);
            e_r     = !op && (n < W);
            e_done  = (n == d);
            e_err   = (n == d) && exp_err;
            e_busy  = (n <= d);
            e_ready = (n > d);
            chk_cnt++;
            if (S !== e_s) begin
                fail_cnt++;
                $display("FAIL %s S n=%0d got %b want %b", tag, n, S, e_s);
            end
            chk_cnt++;
            if (R !== e_r) begin
                fail_cnt++;
                $display("FAIL %s R n=%0d got %b want %b", tag, n, R, e_r);
            end
            chk_cnt++;
            if ((S & R) !== 1'b0) begin
                fail_cnt++;
                $display("FAIL %s S&R n=%0d got %b want 0", tag, n, S & R);
            end
            chk_cnt++;
            if (done !== e_done) begin
                fail_cnt++;
                $display("FAIL %s done n=%0d got %b want %b", tag, n, done, e_done);
            end
            chk_cnt++;
            if (err !== e_err) begin
                fail_cnt++;
                $display("FAIL %s err n=%0d got %b want %b", tag, n, err, e_err);
            end
            chk_cnt++;
            if (busy !== e_busy) begin
                fail_cnt++;
                $display("FAIL %s busy n=%0d got %b want %b", tag, n, busy, e_busy);
            end
            chk_cnt++;
            if (cmd_ready !== e_ready) begin
                fail_cnt++;
                $display("FAIL %s cmd_ready n=%0d got %b want %b", tag, n, cmd_ready, e_ready);
            end
            if (n == d && !exp_err) exp_state = op;
            if (n != d) begin
                chk_cnt++;
                if (state_q !== exp_state) begin
                    fail_cnt++;
                    $display("FAIL %s state_q n=%0d got %b want %b", tag, n, state_q, exp_state);
                end
            end
            if (!hold && n == 0) cmd_valid = 1'b0;
            if (hold) cmd_op = ~cmd_op;
        end
        next_op = cmd_op;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({S, R, cmd_ready, done, err, busy, state_q} !== 7'b0) begin
            fail_cnt++;
            $display("FAIL reset_values got %b want 0000000",
                     {S, R, cmd_ready, done, err, busy, state_q});
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({cmd_ready, busy} !== 2'b10) begin
            fail_cnt++;
            $display("FAIL reset_release ready/busy got %b want 10", {cmd_ready, busy});
        end
        exp_state = 1'b0;
    endtask

    task automatic test_set();
        bit nx;
        idle(3);
        run_cmd(1'b1, 1'b0, "set", nx);
    endtask

    task automatic test_reset_cmd();
        bit nx;
        idle(2);
        run_cmd(1'b0, 1'b0, "reset_cmd", nx);
    endtask

    task automatic test_stuck();
        bit nx;
        set_mode(M_FORCED, 1'b0, 1'b1);
        run_cmd(1'b1, 1'b0, "stuck_set", nx);
        idle(2);
        run_cmd(1'b0, 1'b0, "same_op", nx);
    endtask

    task automatic test_illegal();
        bit nx;
        set_mode(M_FORCED, 1'b1, 1'b1);
        run_cmd(1'b0, 1'b0, "illegal", nx);
    endtask

    task automatic test_reset_mid_pulse();
        set_mode(M_NORMAL, 1'b1, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n     = 1'b0;              // edge opening the 2nd pulse cycle sees reset
        @(negedge clk);
        chk_cnt++;
        if ({S, R, done, err, busy, cmd_ready} !== 6'b0) begin
            fail_cnt++;
            $display("FAIL mid_pulse_reset S/R/done/err/busy/ready got %b want 000000",
                     {S, R, done, err, busy, cmd_ready});
        end
        rst_n = 1'b1;
        exp_state = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({cmd_ready, busy, state_q} !== 3'b100) begin
            fail_cnt++;
            $display("FAIL mid_pulse_release ready/busy/state_q got %b want 100",
                     {cmd_ready, busy, state_q});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({done, S, R} !== 3'b000) begin
                fail_cnt++;
                $display("FAIL mid_pulse_quiet cycle=%0d done/S/R got %b want 000", i, {done, S, R});
            end
        end
    endtask

    task automatic test_held_request();
        bit nx;
        idle(3);
        nx = ~q;
        for (int i = 0; i < 4; i++) run_cmd(nx, 1'b1, "held", nx);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({busy, cmd_ready} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL held_release busy/ready got %b want 01", {busy, cmd_ready});
        end
    endtask

    task automatic test_random();
        bit nx;
        int r;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                nx = 1'($urandom_range(0, 1));
                set_mode(M_FORCED, nx, ~nx);              // stuck at a legal value
            end else if (r == 1) begin
                nx = 1'($urandom_range(0, 1));
                set_mode(M_FORCED, nx, nx);               // illegal feedback
            end else if (mode != M_NORMAL) begin
                set_mode(M_NORMAL, force_q, force_qb);
            end
            idle($urandom_range(3, 6));
            run_cmd(1'($urandom_range(0, 1)), 1'b0, "random", nx);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_reset_cmd();
        test_stuck();
        test_illegal();
        test_reset_mid_pulse();
        test_held_request();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
